// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stall, taken-beq flush,
// EX operand forwarding selects and saturating stall/flush event counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic [4:0]       idRd,
    input  logic             idRegDst,
    input  logic             idMemRead,
    input  logic             idRegWrite,
    input  logic             idBranch,
    input  logic             exZero,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             ctrlNop,
    output logic             pcSrc,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow of ID/EX, EX/MEM and MEM/WB destination information
    logic       r_e_valid;
    logic       r_e_mem_read;
    logic       r_e_reg_write;
    logic       r_e_branch;
    logic [4:0] r_e_dst;
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;
    logic       r_m_reg_write;
    logic [4:0] r_m_dst;
    logic       r_w_reg_write;
    logic [4:0] r_w_dst;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [4:0] w_id_dst;
    logic       w_take;
    logic       w_load_use;

    // Nearest older writer wins; $0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_dst,
        input logic       w_we,
        input logic [4:0] w_dst
    );
        logic [1:0] sel;
        if (m_we && (m_dst != 5'd0) && (m_dst == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_dst != 5'd0) && (w_dst == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign w_id_dst   = idRegDst ? idRd : idRt;
    assign w_take     = r_e_valid & r_e_branch & exZero;
    assign w_load_use = r_e_valid & r_e_mem_read & (r_e_dst != 5'd0) &
                        ((r_e_dst == idRs) | (r_e_dst == idRt));

    // Pipeline control: a taken branch squashes ID, so it overrides a load-use stall
    always_comb begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        ctrlNop   = 1'b0;
        pcSrc     = 1'b0;
        if (w_take) begin
            pcSrc     = 1'b1;
            ifIdFlush = 1'b1;
            ctrlNop   = 1'b1;
        end else if (w_load_use) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            ctrlNop   = 1'b1;
        end else begin
            pcWrite   = 1'b1;
            ifIdWrite = 1'b1;
        end
    end

    assign forwardA   = fwd_sel(r_e_rs, r_m_reg_write, r_m_dst, r_w_reg_write, r_w_dst);
    assign forwardB   = fwd_sel(r_e_rt, r_m_reg_write, r_m_dst, r_w_reg_write, r_w_dst);
    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;

    // Advance the shadow pipeline; a bubble enters E whenever ctrlNop is raised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid     <= 1'b0;
            r_e_mem_read  <= 1'b0;
            r_e_reg_write <= 1'b0;
            r_e_branch    <= 1'b0;
            r_e_dst       <= 5'd0;
            r_e_rs        <= 5'd0;
            r_e_rt        <= 5'd0;
            r_m_reg_write <= 1'b0;
            r_m_dst       <= 5'd0;
            r_w_reg_write <= 1'b0;
            r_w_dst       <= 5'd0;
        end else begin
            r_w_reg_write <= r_m_reg_write;
            r_w_dst       <= r_m_dst;
            r_m_reg_write <= r_e_reg_write & r_e_valid;
            r_m_dst       <= r_e_dst;
            if (ctrlNop) begin
                r_e_valid     <= 1'b0;
                r_e_mem_read  <= 1'b0;
                r_e_reg_write <= 1'b0;
                r_e_branch    <= 1'b0;
                r_e_dst       <= 5'd0;
                r_e_rs        <= 5'd0;
                r_e_rt        <= 5'd0;
            end else begin
                r_e_valid     <= 1'b1;
                r_e_mem_read  <= idMemRead;
                r_e_reg_write <= idRegWrite;
                r_e_branch    <= idBranch;
                r_e_dst       <= w_id_dst;
                r_e_rs        <= idRs;
                r_e_rt        <= idRt;
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_load_use && !w_take && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_take && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand-written reset/saturation
// sequences, and random traffic against an instruction-level reference model.
module tb_hazard_unit;

    localparam int CNT_W = 4;
    localparam logic [4:0] C_DEF   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_TAKE  = 5'b11111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] idRs = 5'd0, idRt = 5'd0, idRd = 5'd0;
    logic idRegDst = 1'b0, idMemRead = 1'b0, idRegWrite = 1'b0, idBranch = 1'b0;
    logic exZero = 1'b0;
    logic pcWrite, ifIdWrite, ifIdFlush, ctrlNop, pcSrc;
    logic [1:0] forwardA, forwardB;
    logic [CNT_W-1:0] stallCount, flushCount;

    int n_chk = 0;
    int n_err = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .idRegDst(idRegDst), .idMemRead(idMemRead), .idRegWrite(idRegWrite), .idBranch(idBranch),
        .exZero(exZero),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .ctrlNop(ctrlNop),
        .pcSrc(pcSrc), .forwardA(forwardA), .forwardB(forwardB),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic rdst, mr, rw, br, ez;
        logic [4:0] ctl;
        logic [1:0] fa, fb;
        int st, fl;
    } vec_t;

    typedef struct {
        bit v, mr, rw, br;
        bit [4:0] dst, rs, rt;
    } ins_t;

    vec_t tbl[18];

    // reference model: instruction in EX plus writers of age 1 and 2
    ins_t   m_ex;
    bit     m_we[1:2];
    bit [4:0] m_wd[1:2];
    int     m_st, m_fl;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {pcWrite, ifIdWrite, ifIdFlush, ctrlNop, pcSrc};
    endfunction

    task automatic drive(input logic [4:0] rs, rt, rd, input logic rdst, mr, rw, br, ez);
        idRs = rs; idRt = rt; idRd = rd;
        idRegDst = rdst; idMemRead = mr; idRegWrite = rw; idBranch = br; exZero = ez;
    endtask

    task automatic model_reset();
        m_ex = '{default: '0};
        m_we[1] = 1'b0; m_we[2] = 1'b0;
        m_wd[1] = 5'd0; m_wd[2] = 5'd0;
        m_st = 0; m_fl = 0;
    endtask

    function automatic logic [1:0] model_fwd(input bit [4:0] r);
        for (int age = 1; age <= 2; age++) begin
            if (m_we[age] && m_wd[age] != 5'd0 && m_wd[age] == r)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [4:0] exp_ctl;
        bit take, lu;
        int max_cnt;
        max_cnt = (1 << CNT_W) - 1;

        // rs rt rd rdst mr rw br ez | ctl fa fb | stall flush
        tbl[0]  = '{5'd1,  5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 0, 0};
        tbl[1]  = '{5'd8,  5'd2,  5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, 2'b00, 2'b00, 0, 0};
        tbl[2]  = '{5'd8,  5'd2,  5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 0};
        tbl[3]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF,   2'b01, 2'b00, 1, 0};
        tbl[4]  = '{5'd4,  5'd5,  5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 0};
        tbl[5]  = '{5'd3,  5'd3,  5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 0};
        tbl[6]  = '{5'd3,  5'd3,  5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_DEF,   2'b10, 2'b10, 1, 0};
        tbl[7]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_DEF,   2'b01, 2'b01, 1, 0};
        tbl[8]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 0};
        tbl[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 0};
        tbl[10] = '{5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_DEF,   2'b00, 2'b00, 1, 0};
        tbl[11] = '{5'd11, 5'd12, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_TAKE,  2'b00, 2'b00, 1, 0};
        tbl[12] = '{5'd11, 5'd12, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_DEF,   2'b00, 2'b00, 1, 1};
        tbl[13] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_DEF,   2'b00, 2'b00, 1, 1};
        tbl[14] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 1};
        tbl[15] = '{5'd0,  5'd13, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_DEF,   2'b00, 2'b00, 1, 1};
        tbl[16] = '{5'd13, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_TAKE,  2'b00, 2'b00, 1, 1};
        tbl[17] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF,   2'b00, 2'b00, 1, 2};

        // reset while a load sits in ID, then the load must reach E
        @(negedge clk);
        rst_n = 1'b0;
        drive(5'd5, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rst_ctl", ctl_now(), C_DEF);
        chk("rst_fa", forwardA, 2'b00);
        chk("rst_fb", forwardB, 2'b00);
        chk("rst_stall", stallCount, 0);
        chk("rst_flush", flushCount, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ctl", ctl_now(), C_DEF);
        @(negedge clk);
        idRs = 5'd6;
        #1;
        chk("load_in_e", ctl_now(), C_STALL);

        // directed vector table
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].rdst, tbl[i].mr, tbl[i].rw, tbl[i].br, tbl[i].ez);
            #1;
            chk($sformatf("v%0d_ctl", i), ctl_now(), tbl[i].ctl);
            chk($sformatf("v%0d_fa", i), forwardA, tbl[i].fa);
            chk($sformatf("v%0d_fb", i), forwardB, tbl[i].fb);
            chk($sformatf("v%0d_stall", i), stallCount, tbl[i].st);
            chk($sformatf("v%0d_flush", i), flushCount, tbl[i].fl);
        end

        // stall counter saturation, then asynchronous reset in the middle of a stall
        do_reset();
        drive(5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2 * ((1 << CNT_W) + 3)) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_stall", stallCount, max_cnt);
        chk("sat_bubble_ctl", ctl_now(), C_DEF);
        @(negedge clk);
        #1;
        chk("sat_midstall_ctl", ctl_now(), C_STALL);
        chk("sat_hold", stallCount, max_cnt);
        rst_n = 1'b0;
        #1;
        chk("async_stall", stallCount, 0);
        chk("async_nop", ctrlNop, 0);
        chk("async_pcw", pcWrite, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rel_ctl", ctl_now(), C_DEF);

        // random traffic against the instruction-level model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            #1;
            take = m_ex.v && m_ex.br && exZero;
            lu   = m_ex.v && m_ex.mr && m_ex.dst != 5'd0 && (m_ex.dst == idRs || m_ex.dst == idRt);
            exp_ctl = take ? C_TAKE : (lu ? C_STALL : C_DEF);
            chk("rnd_ctl", ctl_now(), exp_ctl);
            chk("rnd_fa", forwardA, model_fwd(m_ex.rs));
            chk("rnd_fb", forwardB, model_fwd(m_ex.rt));
            chk("rnd_stall", stallCount, m_st);
            chk("rnd_flush", flushCount, m_fl);
            // effects of the coming clock edge
            if (lu && !take && m_st < max_cnt) m_st++;
            if (take && m_fl < max_cnt) m_fl++;
            m_we[2] = m_we[1]; m_wd[2] = m_wd[1];
            m_we[1] = m_ex.v && m_ex.rw; m_wd[1] = m_ex.dst;
            if (take || lu) begin
                m_ex = '{default: '0};
            end else begin
                m_ex.v = 1'b1; m_ex.mr = idMemRead; m_ex.rw = idRegWrite; m_ex.br = idBranch;
                m_ex.dst = idRegDst ? idRd : idRt; m_ex.rs = idRs; m_ex.rt = idRt;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
